mem_share_arbiter: RTL and testbench

//  Shares the single-port 256x16 data/instruction RAM between two requesters:

---
 rtl/mem_share_arbiter_if.sv | 18 +
 rtl/mem_share_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_share_arbiter_if.sv
// Requester-side bus for mem_share_arbiter: request/command in, grant and read return out.
// master = requester (CPU or I/O loader), slave = arbiter.
interface mem_share_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_share_arbiter.sv
// Round-robin sharer of one registered-read RAM between port A (CPU) and port B (I/O loader),
// with lockable bursts capped by MAX_HOLD. Optional wait statistics: MEM_SHARE_ARB_STATS_EN.
module mem_share_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_share_arbiter_if.slave a_port,
    mem_share_arbiter_if.slave b_port,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_SHARE_ARB_STATS_EN
    ,
    output logic [7:0]        a_wait_max,
    output logic [7:0]        b_wait_max
`endif
);

    localparam int unsigned       HOLD_W   = 4;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [1:0]        OWN_NONE = 2'd0;
    localparam logic [1:0]        OWN_A    = 2'd1;
    localparam logic [1:0]        OWN_B    = 2'd2;
    localparam logic              PRIO_A   = 1'b0;
    localparam logic              PRIO_B   = 1'b1;

    logic [1:0]        owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q, a_rdata_c, b_rdata_c;
    logic              gnt_a, gnt_b, force_brk, hold_full;

    assign hold_full = (hold_q == HOLD_MAX);

    // Grant selection: locked owner first, forced hand-over at the hold limit, else round-robin.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        force_brk = 1'b0;
        if (reset_n) begin
            if (owner_q == OWN_A && a_port.req) begin
                if (b_port.req && hold_full) begin
                    gnt_b     = 1'b1;
                    force_brk = 1'b1;
                end else begin
                    gnt_a = 1'b1;
                end
            end else if (owner_q == OWN_B && b_port.req) begin
                if (a_port.req && hold_full) begin
                    gnt_a     = 1'b1;
                    force_brk = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else if (a_port.req && b_port.req) begin
                gnt_a = (prio_q == PRIO_A);
                gnt_b = (prio_q == PRIO_B);
            end else begin
                gnt_a = a_port.req;
                gnt_b = b_port.req;
            end
        end
    end

    // Ownership, priority and hold counter; no grant means any owner has dropped its request.
    always_comb begin
        owner_d = owner_q;
        prio_d  = prio_q;
        hold_d  = hold_q;
        rd_a_d  = gnt_a && !a_port.we;
        rd_b_d  = gnt_b && !b_port.we;
        if (gnt_a) prio_d = PRIO_B;
        if (gnt_b) prio_d = PRIO_A;
        if (force_brk) begin
            owner_d = OWN_NONE;
            hold_d  = '0;
        end else if (gnt_a) begin
            owner_d = a_port.lock ? OWN_A : OWN_NONE;
            if (owner_q == OWN_A && a_port.lock && b_port.req)
                hold_d = hold_full ? hold_q : hold_q + HOLD_W'(1);
            else
                hold_d = '0;
        end else if (gnt_b) begin
            owner_d = b_port.lock ? OWN_B : OWN_NONE;
            if (owner_q == OWN_B && b_port.lock && a_port.req)
                hold_d = hold_full ? hold_q : hold_q + HOLD_W'(1);
            else
                hold_d = '0;
        end else begin
            owner_d = OWN_NONE;
            hold_d  = '0;
        end
    end

    // RAM command mux; address holds when idle to avoid needless toggling.
    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (gnt_a) begin
            mem_addr  = a_port.addr;
            mem_we    = a_port.we;
            mem_wdata = a_port.wdata;
        end else if (gnt_b) begin
            mem_addr  = b_port.addr;
            mem_we    = b_port.we;
            mem_wdata = b_port.wdata;
        end
    end

    assign a_rdata_c     = rd_a_q ? mem_rdata : a_rdata_q;
    assign b_rdata_c     = rd_b_q ? mem_rdata : b_rdata_q;
    assign a_port.gnt    = gnt_a;
    assign b_port.gnt    = gnt_b;
    assign a_port.rvalid = rd_a_q;
    assign b_port.rvalid = rd_b_q;
    assign a_port.rdata  = a_rdata_c;
    assign b_port.rdata  = b_rdata_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q   <= OWN_NONE;
            prio_q    <= PRIO_A;
            hold_q    <= '0;
            addr_q    <= '0;
            rd_a_q    <= 1'b0;
            rd_b_q    <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            hold_q    <= hold_d;
            addr_q    <= mem_addr;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            a_rdata_q <= a_rdata_c;
            b_rdata_q <= b_rdata_c;
        end
    end

`ifdef MEM_SHARE_ARB_STATS_EN
    logic [7:0] a_wcur_q, a_wcur_d, a_wmax_q, a_wmax_d;
    logic [7:0] b_wcur_q, b_wcur_d, b_wmax_q, b_wmax_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Current run of ungranted request cycles per port and its high-water mark.
    always_comb begin
        a_wcur_d = (a_port.req && !gnt_a) ? sat_inc8(a_wcur_q) : 8'd0;
        b_wcur_d = (b_port.req && !gnt_b) ? sat_inc8(b_wcur_q) : 8'd0;
        a_wmax_d = (a_wcur_d > a_wmax_q) ? a_wcur_d : a_wmax_q;
        b_wmax_d = (b_wcur_d > b_wmax_q) ? b_wcur_d : b_wmax_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_wcur_q <= '0;
            a_wmax_q <= '0;
            b_wcur_q <= '0;
            b_wmax_q <= '0;
        end else begin
            a_wcur_q <= a_wcur_d;
            a_wmax_q <= a_wmax_d;
            b_wcur_q <= b_wcur_d;
            b_wmax_q <= b_wmax_d;
        end
    end

    assign a_wait_max = a_wmax_q;
    assign b_wait_max = b_wmax_q;
`endif

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Self-checking bench for mem_share_arbiter: directed vector table, burst/reset sequences,
// and a randomized run against a behavioural model. Define MEM_SHARE_ARB_STATS_EN to check the stats.
module tb_mem_share_arbiter;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned MAX_HOLD = 4;
    localparam int          NV       = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_share_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    mem_share_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_SHARE_ARB_STATS_EN
    logic [7:0] a_wait_max, b_wait_max;
`endif

    mem_share_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_port    (a_if),
        .b_port    (b_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_SHARE_ARB_STATS_EN
        ,
        .a_wait_max(a_wait_max),
        .b_wait_max(b_wait_max)
`endif
    );

    function automatic logic [15:0] iv(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {8'hA5 ^ a, a};
    endfunction

    // Write-first RAM with registered read.
    logic [15:0] ram [256];
    logic        ram_load = 1'b0;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= iv(8'(i));
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic ar, aw, al, input logic [7:0] aa, input logic [15:0] ad,
                         input logic br, bw, bl, input logic [7:0] ba, input logic [15:0] bd);
        a_if.req = ar; a_if.we = aw; a_if.lock = al; a_if.addr = aa; a_if.wdata = ad;
        b_if.req = br; b_if.we = bw; b_if.lock = bl; b_if.addr = ba; b_if.wdata = bd;
    endtask

    // Both ports request during reset: grants must stay low and outputs at reset values.
    task automatic do_reset(input logic load);
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h07, 16'h0, 1'b1, 1'b0, 1'b0, 8'h08, 16'h0);
        ram_load = load;
        @(negedge clk);
        chk("rst_a_gnt", 32'(a_if.gnt), 32'd0);
        chk("rst_b_gnt", 32'(b_if.gnt), 32'd0);
        chk("rst_a_rvalid", 32'(a_if.rvalid), 32'd0);
        chk("rst_b_rvalid", 32'(b_if.rvalid), 32'd0);
        chk("rst_a_rdata", 32'(a_if.rdata), 32'd0);
        chk("rst_b_rdata", 32'(b_if.rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 ram_load = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst;
        logic ar, aw, al; logic [7:0] aa; logic [15:0] ad;
        logic br, bw, bl; logic [7:0] ba; logic [15:0] bd;
        logic eag, ebg; logic [7:0] ema; logic emw; logic [15:0] emd;
        logic earv, ebrv; logic [15:0] eard, ebrd;
    } vec_t;
    vec_t vt [NV];

    // Test 3 and random-model state.
    int   a_cnt, c, got, exp_g;
    bit   b_done;
    bit   ir [2], iw [2], il [2], lg [2], m_pend [2];
    logic [7:0]  ia [2];
    logic [15:0] id [2], m_pdata [2], m_hold [2], erd [2];
    logic [15:0] m_ram [256];
    logic [7:0]  m_last, e_addr;
    logic        e_we;
    logic [15:0] e_wdata;
    int   m_owner, m_rr, m_run, g, nown;
    bit   brk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 1'b1,1'b0,1'b0,8'h10,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0,
                  1'b1,1'b0,8'h10,1'b0,16'h0, 1'b0,1'b0,16'h0,16'h0};
        vt[1] = '{1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0,
                  1'b0,1'b0,8'h10,1'b0,16'h0, 1'b1,1'b0,16'hBEEF,16'h0};
        vt[2] = '{1'b1, 1'b1,1'b0,1'b0,8'h01,16'h0, 1'b1,1'b0,1'b0,8'h02,16'h0,
                  1'b1,1'b0,8'h01,1'b0,16'h0, 1'b0,1'b0,16'h0,16'h0};
        vt[3] = '{1'b0, 1'b1,1'b0,1'b0,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h02,16'h0,
                  1'b0,1'b1,8'h02,1'b0,16'h0, 1'b1,1'b0,iv(8'h01),16'h0};
        vt[4] = '{1'b0, 1'b1,1'b0,1'b0,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h04,16'h0,
                  1'b1,1'b0,8'h03,1'b0,16'h0, 1'b0,1'b1,iv(8'h01),iv(8'h02)};
        vt[5] = '{1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,8'h04,16'h0,
                  1'b0,1'b1,8'h04,1'b0,16'h0, 1'b1,1'b0,iv(8'h03),iv(8'h02)};
        vt[6] = '{1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0,
                  1'b0,1'b0,8'h04,1'b0,16'h0, 1'b0,1'b1,iv(8'h03),iv(8'h04)};
        vt[7] = '{1'b1, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b1,1'b0,8'h20,16'h1234,
                  1'b0,1'b1,8'h20,1'b1,16'h1234, 1'b0,1'b0,16'h0,16'h0};
        vt[8] = '{1'b0, 1'b1,1'b0,1'b0,8'h20,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0,
                  1'b1,1'b0,8'h20,1'b0,16'h0, 1'b0,1'b0,16'h0,16'h0};
        vt[9] = '{1'b0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0,
                  1'b0,1'b0,8'h20,1'b0,16'h0, 1'b1,1'b0,16'h1234,16'h0};

        do_reset(1'b1);
        for (int i = 0; i < NV; i++) begin
            if (vt[i].rst) do_reset(1'b0);
            drive(vt[i].ar, vt[i].aw, vt[i].al, vt[i].aa, vt[i].ad,
                  vt[i].br, vt[i].bw, vt[i].bl, vt[i].ba, vt[i].bd);
            @(negedge clk);
            chk($sformatf("v%0d_a_gnt", i), 32'(a_if.gnt), 32'(vt[i].eag));
            chk($sformatf("v%0d_b_gnt", i), 32'(b_if.gnt), 32'(vt[i].ebg));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].ema));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].emw));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vt[i].emd));
            chk($sformatf("v%0d_a_rvalid", i), 32'(a_if.rvalid), 32'(vt[i].earv));
            chk($sformatf("v%0d_b_rvalid", i), 32'(b_if.rvalid), 32'(vt[i].ebrv));
            chk($sformatf("v%0d_a_rdata", i), 32'(a_if.rdata), 32'(vt[i].eard));
            chk($sformatf("v%0d_b_rdata", i), 32'(b_if.rdata), 32'(vt[i].ebrd));
            @(posedge clk);
            #1;
        end

        // Locked A burst of 8 reads against a waiting B: A x5, B, A x3.
        do_reset(1'b0);
        a_cnt = 0; b_done = 0; c = 0;
        while ((a_cnt < 8 || !b_done) && c < 20) begin
            drive(a_cnt < 8, 1'b0, 1'b1, 8'(8'h40 + a_cnt), 16'h0, !b_done, 1'b0, 1'b0, 8'h30, 16'h0);
            @(negedge clk);
            got   = a_if.gnt ? 1 : (b_if.gnt ? 2 : 0);
            exp_g = (c == 5) ? 2 : 1;
            chk($sformatf("t3_c%0d_gnt", c), 32'(got), 32'(exp_g));
            if (a_if.gnt) a_cnt++;
            if (b_if.gnt) b_done = 1;
            @(posedge clk);
            #1 c++;
        end
        chk("t3_cycles", 32'(c), 32'd9);
        drive(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0, 16'h0);
`ifdef MEM_SHARE_ARB_STATS_EN
        @(negedge clk);
        chk("t6_b_wait_max", 32'(b_wait_max), 32'd5);
        chk("t6_a_wait_max", 32'(a_wait_max), 32'd1);
        @(posedge clk);
        #1;
`endif

        // Reset right after an A read grant: the pending response must vanish.
        do_reset(1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h10, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
        chk("t5_a_gnt", 32'(a_if.gnt), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h11, 16'h0, 1'b1, 1'b0, 1'b0, 8'h12, 16'h0);
        #1;
        chk("t5_rvalid_in_rst", 32'(a_if.rvalid), 32'd0);
        chk("t5_gnt_in_rst", 32'(a_if.gnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("t5_prio_a_gnt", 32'(a_if.gnt), 32'd1);
        chk("t5_prio_b_gnt", 32'(b_if.gnt), 32'd0);
        chk("t5_no_spurious_rvalid", 32'(a_if.rvalid), 32'd0);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0, 16'h0);
        @(negedge clk);
        chk("t5_read_after_release", 32'(a_if.rvalid), 32'd1);
        chk("t5_rdata_after_release", 32'(a_if.rdata), 32'(iv(8'h11)));
        @(posedge clk);
        #1;

        // Randomized traffic against the behavioural model.
        do_reset(1'b0);
        for (int i = 0; i < 256; i++) m_ram[i] = ram[i];
        m_owner = -1; m_rr = 0; m_run = 0; m_last = 8'h00;
        for (int p = 0; p < 2; p++) begin
            ir[p] = 0; lg[p] = 0; m_pend[p] = 0; m_hold[p] = 16'h0; m_pdata[p] = 16'h0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!ir[p] || lg[p]) begin
                    ir[p] = ($urandom_range(0, 3) != 0);
                    iw[p] = ($urandom_range(0, 2) == 0);
                    il[p] = ($urandom_range(0, 1) == 1);
                    ia[p] = 8'($urandom_range(0, 15));
                    id[p] = 16'($urandom);
                end
            end
            drive(ir[0], iw[0], il[0], ia[0], id[0], ir[1], iw[1], il[1], ia[1], id[1]);
            @(negedge clk);
            g = -1; brk = 0;
            if (m_owner >= 0 && ir[m_owner]) begin
                if (ir[1 - m_owner] && m_run == int'(MAX_HOLD)) begin
                    g = 1 - m_owner; brk = 1;
                end else g = m_owner;
            end else if (ir[0] && ir[1]) g = m_rr;
            else if (ir[0]) g = 0;
            else if (ir[1]) g = 1;
            e_addr = m_last; e_we = 1'b0; e_wdata = 16'h0;
            if (g >= 0) begin
                e_addr = ia[g]; e_we = iw[g]; e_wdata = id[g];
            end
            for (int p = 0; p < 2; p++) erd[p] = m_pend[p] ? m_pdata[p] : m_hold[p];
            chk("rnd_a_gnt", 32'(a_if.gnt), 32'(g == 0));
            chk("rnd_b_gnt", 32'(b_if.gnt), 32'(g == 1));
            chk("rnd_mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("rnd_mem_we", 32'(mem_we), 32'(e_we));
            chk("rnd_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            chk("rnd_a_rvalid", 32'(a_if.rvalid), 32'(m_pend[0]));
            chk("rnd_b_rvalid", 32'(b_if.rvalid), 32'(m_pend[1]));
            chk("rnd_a_rdata", 32'(a_if.rdata), 32'(erd[0]));
            chk("rnd_b_rdata", 32'(b_if.rdata), 32'(erd[1]));
            lg[0] = a_if.gnt; lg[1] = b_if.gnt;
            for (int p = 0; p < 2; p++) begin
                m_hold[p] = erd[p];
                m_pend[p] = (g == p) && !iw[p];
                if (m_pend[p]) m_pdata[p] = m_ram[ia[p]];
            end
            m_last = e_addr;
            if (g >= 0) begin
                if (iw[g]) m_ram[ia[g]] = id[g];
                m_rr = 1 - g;
                if (brk) begin
                    m_owner = -1; m_run = 0;
                end else begin
                    nown = il[g] ? g : -1;
                    if (g == m_owner && nown == m_owner && ir[1 - g])
                        m_run = (m_run < int'(MAX_HOLD)) ? m_run + 1 : m_run;
                    else
                        m_run = 0;
                    m_owner = nown;
                end
            end else begin
                m_owner = -1; m_run = 0;
            end
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
